ex_stage: RTL
=============

Name: ex_stage

Overview:
- Integer execute stage directly downstream of the integer register file / divider block.
- Consumes rs1_data/rs2_data and produces the X-stage result (rd_data_x) and the M-stage result (rd_data_m), which the register file uses for bypass and write-back.
- Also returns the subtractor result (alu_l) and the operand-equality flag (eq_o) that drive the register file's iterative divider.
- Contains a 2-stage pipelined RV32M multiplier.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_v  in  1  valid instruction in X this cycle; low means bubble
- alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 reserved
- use_imm  in  1  operand B = imm instead of rs2_data
- imm  in  32  decoded immediate
- alu_uns  in  1  zero-extend (not sign-extend) operands for alu_l
- rs1_data  in  32  operand A from the register file
- rs2_data  in  32  operand B from the register file
- rd_data_x  out  32  combinational X-stage result for non-multiply ops
- alu_l  out  34  ext(rs1_data) - ext(rs2_data), combinational
- eq_o  out  1  rs1_data == rs2_data, combinational
- rd_data_m  out  32  M-stage result, one cycle after X
- m_v  out  1  rd_data_m carries a valid instruction result

Behaviour:
- Operand B: opB = use_imm ? imm : rs2_data. alu_l and eq_o always use rs2_data and ignore use_imm, because the divider depends on them.
- alu_l:
  - ext is sign-extension to 34 bits when alu_uns=0, zero-extension when alu_uns=1.
  - Full 34-bit result; bit 33 is the sign.
  - Valid every cycle, regardless of ex_v.
- rd_data_x:
  - Shifts use opB[4:0]. SLT/SLTU return 1 or 0. PASSB returns opB.
  - Ops 11-15 return 0. Decode never asserts X-stage bypass for multiplies.
- X-to-M registers (capture only when ex_v=1; hold otherwise):
  - ALU result.
  - A 2-bit op tag: 0 = ALU, 1 = MUL-low, 2 = MUL-high.
  - Four multiplier partial products.
- m_v <= ex_v every cycle.
- Multiplier:
  - Operands are extended to 33 bits: a is signed for MULH/MULHSU, b is signed for MULH only; MUL may use either.
  - Split a = a_hi(17b, signed) : a_lo(16b, unsigned), and the same for b.
  - In X, register pp_ll = a_lo*b_lo, pp_lh = a_lo*b_hi, pp_hl = a_hi*b_lo, pp_hh = a_hi*b_hi.
  - In M, combinationally sum = pp_ll + ((pp_lh+pp_hl)<<16) + (pp_hh<<32) at 66-bit signed width.
  - MUL returns sum[31:0]; MULH/MULHSU/MULHU return sum[63:32].
- rd_data_m: selected by the op tag between the registered ALU result and the multiplier sum.
- Latency: ALU result is in X (rd_data_x) and in M (rd_data_m). Multiply result is in M only.
- Throughput: back-to-back multiplies are supported, one result per cycle, with no stall.
- Reserved op 15: rd_data_x = 0; rd_data_m = 0 when ex_v=1.
- Reset (synchronous):
  - m_v = 0.
  - All X-to-M registers = 0, so rd_data_m = 0 after reset.
  - A multiply in flight when reset is asserted is discarded.
  - rd_data_x, alu_l and eq_o are combinational and have no reset state.
- Simultaneous ex_v=1 and reset: reset wins; no capture occurs.
- Divider interaction: while the register file is dividing, ex_v is 0 and rs1_data/rs2_data carry the remainder and divisor. alu_l/eq_o must still track the operands each cycle, and the M registers hold their values.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: the multiplier and partial-product registers are present, as described above.
- Undefined:
  - Partial-product registers and the adder tree are removed.
  - Ops 11-14 behave as reserved: rd_data_m = 0 with m_v still following ex_v.
  - ALU, alu_l and eq_o behaviour is unchanged.

Test Plan:
- ALU: ex_v=1, ADD, rs1=0x7FFFFFFF, rs2=1 -> rd_data_x=0x80000000 the same cycle; next cycle rd_data_m=0x80000000, m_v=1.
- SRA: use_imm=1, imm=4, rs1=0x80000000 -> rd_data_x=0xF8000000. SLTU with rs1=1, rs2=0xFFFFFFFF -> rd_data_x=1.
- alu_l/eq_o:
  - rs1=0, rs2=5, alu_uns=0 -> alu_l=0x3FFFFFFFB, eq_o=0.
  - rs1=0xFFFFFFFF, rs2=1, alu_uns=1 -> alu_l=0x0FFFFFFFE.
  - rs1=rs2=0x1234 -> eq_o=1.
- Multiply back-to-back over 4 cycles:
  - MUL -1*-1 -> rd_data_m=0x00000001.
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - Each result appears one cycle after its X cycle; m_v stays high throughout.
- Bubble hold: MUL result 6, then ex_v=0 for 3 cycles with changing operands -> m_v=0, rd_data_m holds 6.
- Reset mid-operation: MULHU in X with reset=1 -> next cycle m_v=0, rd_data_m=0.
- With EX_MUL_EN undefined: MUL 3*4 -> rd_data_m=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// Execute-stage bus: operands and control from decode / register file in,
// X-stage, M-stage and divider-support results back out.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_v;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic            alu_uns;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] rd_data_x;
    logic [XLEN+1:0] alu_l;
    logic            eq_o;
    logic [XLEN-1:0] rd_data_m;
    logic            m_v;

    modport master (
        output ex_v, alu_op, use_imm, imm, alu_uns, rs1_data, rs2_data,
        input  rd_data_x, alu_l, eq_o, rd_data_m, m_v
    );

    modport slave (
        input  ex_v, alu_op, use_imm, imm, alu_uns, rs1_data, rs2_data,
        output rd_data_x, alu_l, eq_o, rd_data_m, m_v
    );
endinterface

// File: rtl/ex_stage.sv
// Integer execute stage: combinational ALU in X, X-to-M pipeline register,
// divider-support subtractor/equality, and a 2-stage RV32M multiplier.
// Define EX_MUL_EN to build the multiplier; without it ops 11-14 act as
// reserved (rd_data_m = 0) and the partial-product logic is removed.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLL = 4'd2,  OP_SLT = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4, OP_XOR = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
    localparam logic [3:0] OP_OR = 4'd8,   OP_AND = 4'd9,  OP_PASSB = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_MULH = 4'd12, OP_MULHSU = 4'd13, OP_MULHU = 4'd14;

    localparam logic [1:0] TAG_ALU = 2'd0, TAG_MUL_LO = 2'd1, TAG_MUL_HI = 2'd2;

    logic [XLEN-1:0] opb;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [1:0]      tag;
    logic [XLEN-1:0] alu_res_p1;
    logic [1:0]      tag_p1;
    logic            vld_p1;

    function automatic logic [XLEN+1:0] ext34(input logic [XLEN-1:0] v, input logic uns);
        return uns ? {2'b00, v} : {{2{v[XLEN-1]}}, v};
    endfunction

    assign opb   = bus.use_imm ? bus.imm : bus.rs2_data;
    assign shamt = opb[4:0];

    // Divider support: always live, always on rs2_data regardless of use_imm or ex_v
    always_comb begin
        bus.alu_l = ext34(bus.rs1_data, bus.alu_uns) - ext34(bus.rs2_data, bus.alu_uns);
        bus.eq_o  = (bus.rs1_data == bus.rs2_data);
    end

    // X-stage ALU result and M-stage result tag
    always_comb begin
        alu_res = '0;
        tag     = TAG_ALU;
        case (bus.alu_op)
            OP_ADD:   alu_res = bus.rs1_data + opb;
            OP_SUB:   alu_res = bus.rs1_data - opb;
            OP_SLL:   alu_res = bus.rs1_data << shamt;
            OP_SLT:   alu_res = {31'b0, $signed(bus.rs1_data) < $signed(opb)};
            OP_SLTU:  alu_res = {31'b0, bus.rs1_data < opb};
            OP_XOR:   alu_res = bus.rs1_data ^ opb;
            OP_SRL:   alu_res = bus.rs1_data >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(bus.rs1_data) >>> shamt);
            OP_OR:    alu_res = bus.rs1_data | opb;
            OP_AND:   alu_res = bus.rs1_data & opb;
            OP_PASSB: alu_res = opb;
            OP_MUL:   tag     = TAG_MUL_LO;
            OP_MULH, OP_MULHSU, OP_MULHU: tag = TAG_MUL_HI;
            default:  alu_res = '0;
        endcase
    end

    assign bus.rd_data_x = alu_res;

    // X-to-M control/ALU register: capture on valid X, hold through bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            alu_res_p1 <= '0;
            tag_p1     <= TAG_ALU;
        end else begin
            vld_p1 <= bus.ex_v;
            if (bus.ex_v) begin
                alu_res_p1 <= alu_res;
                tag_p1     <= tag;
            end
        end
    end

    assign bus.m_v = vld_p1;

`ifdef EX_MUL_EN
    logic                a_sgn, b_sgn;
    logic signed [32:0]  a_ext, b_ext;
    logic signed [33:0]  a_hi, b_hi, a_lo, b_lo;
    logic [31:0]         pp_ll;
    logic signed [33:0]  pp_lh, pp_hl, pp_hh;
    logic [31:0]         pp_ll_p1;
    logic signed [33:0]  pp_lh_p1, pp_hl_p1, pp_hh_p1;
    logic signed [65:0]  sum_m;

    function automatic logic signed [65:0] sx66(input logic signed [33:0] v);
        return {{32{v[33]}}, v};
    endfunction

    // X-stage: 33-bit operand extension, 17b signed / 16b unsigned split, partial products
    always_comb begin
        a_sgn = (bus.alu_op == OP_MULH) || (bus.alu_op == OP_MULHSU);
        b_sgn = (bus.alu_op == OP_MULH);
        a_ext = $signed({a_sgn & bus.rs1_data[31], bus.rs1_data});
        b_ext = $signed({b_sgn & bus.rs2_data[31], bus.rs2_data});
        a_hi  = {{17{a_ext[32]}}, a_ext[32:16]};
        b_hi  = {{17{b_ext[32]}}, b_ext[32:16]};
        a_lo  = {18'b0, a_ext[15:0]};
        b_lo  = {18'b0, b_ext[15:0]};
        pp_ll = {16'b0, a_ext[15:0]} * {16'b0, b_ext[15:0]};
        pp_lh = a_lo * b_hi;
        pp_hl = a_hi * b_lo;
        pp_hh = a_hi * b_hi;
    end

    // X-to-M partial-product register: same capture/hold rule as the ALU result
    always_ff @(posedge clk) begin
        if (reset) begin
            pp_ll_p1 <= '0;
            pp_lh_p1 <= '0;
            pp_hl_p1 <= '0;
            pp_hh_p1 <= '0;
        end else if (bus.ex_v) begin
            pp_ll_p1 <= pp_ll;
            pp_lh_p1 <= pp_lh;
            pp_hl_p1 <= pp_hl;
            pp_hh_p1 <= pp_hh;
        end
    end

    // M-stage: recombine partial products and select the result
    always_comb begin
        sum_m = $signed({34'b0, pp_ll_p1})
              + ((sx66(pp_lh_p1) + sx66(pp_hl_p1)) <<< 16)
              + (sx66(pp_hh_p1) <<< 32);
        case (tag_p1)
            TAG_MUL_LO: bus.rd_data_m = sum_m[31:0];
            TAG_MUL_HI: bus.rd_data_m = sum_m[63:32];
            default:    bus.rd_data_m = alu_res_p1;
        endcase
    end
`else
    // M-stage: no multiplier, multiply tags read as zero
    always_comb begin
        bus.rd_data_m = (tag_p1 == TAG_ALU) ? alu_res_p1 : '0;
    end
`endif

endmodule
